gf2_poly_mult_seq: RTL and testbench



---
 rtl/gf2_poly_mult_seq_if.sv | 22 ++
 rtl/gf2_poly_mult_seq.sv | 106 ++++++++++
 tb/tb_gf2_poly_mult_seq.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gf2_poly_mult_seq_if.sv
// Operand/product handshake bundle for gf2_poly_mult_seq.
// master drives operands and OutReady; slave is the multiplier.
interface gf2_poly_mult_seq_if;
   logic       InValid;
   logic       InReady;
   logic [2:0] X;
   logic [2:0] Y;
   logic       OutValid;
   logic       OutReady;
   logic [4:0] Q;
   logic       Busy;

   modport master (
      output InValid, X, Y, OutReady,
      input  InReady, OutValid, Q, Busy
   );

   modport slave (
      input  InValid, X, Y, OutReady,
      output InReady, OutValid, Q, Busy
   );
endinterface

// File: rtl/gf2_poly_mult_seq.sv
// Bit-serial carry-less GF(2)[x] multiplier, 3x3 -> 5-bit unreduced product.
// Optional macro GF2_POLY_MULT_ZERO_SKIP_EN ends RUN early once the multiplier is exhausted.
module gf2_poly_mult_seq (
   input  logic                 Clk,
   input  logic                 Rst,
   gf2_poly_mult_seq_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [4:0] mx;
   logic [2:0] my;
   logic [4:0] acc;
   logic [1:0] cnt;
   logic       accept;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next   = state;
      accept       = 1'b0;
      bus.InReady  = 1'b0;
      bus.OutValid = 1'b0;
      bus.Busy     = 1'b0;
      bus.Q        = acc;
      unique case (state)
         IDLE: begin
            bus.InReady = 1'b1;
            if (bus.InValid) begin
               accept = 1'b1;
`ifdef GF2_POLY_MULT_ZERO_SKIP_EN
               state_next = (bus.Y == 3'b000) ? DONE : RUN;
`else
               state_next = RUN;
`endif
            end
         end
         RUN: begin
            bus.Busy = 1'b1;
`ifdef GF2_POLY_MULT_ZERO_SKIP_EN
            // my[2:1] is the multiplier left after this edge's shift
            if ((my[2:1] == 2'b00) || (cnt == 2'd2)) begin
               state_next = DONE;
            end
`else
            if (cnt == 2'd2) begin
               state_next = DONE;
            end
`endif
         end
         DONE: begin
            bus.Busy     = 1'b1;
            bus.OutValid = 1'b1;
            if (bus.OutReady) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         mx  <= '0;
         my  <= '0;
         acc <= '0;
         cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  mx  <= {2'b00, bus.X};
                  my  <= bus.Y;
                  acc <= '0;
                  cnt <= '0;
               end
            end
            RUN: begin
               if (my[0]) begin
                  acc <= acc ^ mx;
               end
               mx  <= mx << 1;
               my  <= my >> 1;
               cnt <= cnt + 2'd1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gf2_poly_mult_seq.sv
// Self-checking bench for gf2_poly_mult_seq against a carry-less multiply model.
// Honours GF2_POLY_MULT_ZERO_SKIP_EN for expected latencies.
module tb_gf2_poly_mult_seq;

   logic Clk = 1'b0;
   logic Rst;
   int unsigned n_cmp = 0;
   int unsigned n_fail = 0;

   gf2_poly_mult_seq_if bus ();

   gf2_poly_mult_seq dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   always #5 Clk = ~Clk;

   function automatic logic [4:0] ref_prod(input logic [2:0] a, input logic [2:0] b);
      logic [4:0] p;
      logic [4:0] t;
      p = '0;
      t = {2'b00, a};
      for (int i = 0; i < 3; i++) begin
         if (b[i]) p = p ^ (t << i);
      end
      return p;
   endfunction

   function automatic int ref_lat(input logic [2:0] b);
`ifdef GF2_POLY_MULT_ZERO_SKIP_EN
      if (b[2]) return 3;
      if (b[1]) return 2;
      if (b[0]) return 1;
      return 0;
`else
      return (b == 3'b000) ? 3 : 3;
`endif
   endfunction

   // Entered and left #1 after a rising edge with the block in IDLE.
   task automatic run_op(input logic [2:0] x, input logic [2:0] y, input string tag);
      int lat;
      bus.X = x;
      bus.Y = y;
      bus.InValid = 1'b1;
      bus.OutReady = 1'b1;
      n_cmp++;
      if (bus.InReady !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_inready_before: got %b want 1", tag, bus.InReady);
      end
      @(posedge Clk); #1;
      bus.InValid = 1'b0;
      bus.X = 3'($urandom);
      bus.Y = 3'($urandom);
      lat = 0;
      while (bus.OutValid !== 1'b1 && lat < 12) begin
         @(posedge Clk); #1;
         lat++;
      end
      n_cmp++;
      if (lat !== ref_lat(y)) begin
         n_fail++;
         $display("FAIL %s_latency: got %0d want %0d (x=%0d y=%0d)", tag, lat, ref_lat(y), x, y);
      end
      n_cmp++;
      if (bus.Q !== ref_prod(x, y)) begin
         n_fail++;
         $display("FAIL %s_q: got %h want %h (x=%0d y=%0d)", tag, bus.Q, ref_prod(x, y), x, y);
      end
      n_cmp++;
      if (bus.Busy !== 1'b1 || bus.InReady !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_done_flags: got busy=%b inready=%b want busy=1 inready=0", tag, bus.Busy, bus.InReady);
      end
      @(posedge Clk); #1;
      n_cmp++;
      if (bus.InReady !== 1'b1 || bus.OutValid !== 1'b0 || bus.Busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_back_idle: got inready=%b outvalid=%b busy=%b want 1 0 0", tag, bus.InReady, bus.OutValid, bus.Busy);
      end
   endtask

   task automatic test_reset();
      Rst = 1'b1;
      bus.InValid = 1'b0;
      bus.OutReady = 1'b0;
      bus.X = '0;
      bus.Y = '0;
      @(posedge Clk); @(posedge Clk); #1;
      Rst = 1'b0;
      @(posedge Clk); #1;
      n_cmp++;
      if (bus.InReady !== 1'b1) begin n_fail++; $display("FAIL reset_inready: got %b want 1", bus.InReady); end
      n_cmp++;
      if (bus.OutValid !== 1'b0) begin n_fail++; $display("FAIL reset_outvalid: got %b want 0", bus.OutValid); end
      n_cmp++;
      if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.Busy); end
      n_cmp++;
      if (bus.Q !== 5'h00) begin n_fail++; $display("FAIL reset_q: got %h want 00", bus.Q); end
   endtask

   task automatic test_products();
      logic [2:0] xs [4] = '{3'd7, 3'd5, 3'd6, 3'd4};
      logic [2:0] ys [4] = '{3'd7, 3'd3, 3'd6, 3'd4};
      logic [4:0] qs [4] = '{5'h15, 5'h0F, 5'h14, 5'h10};
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (ref_prod(xs[i], ys[i]) !== qs[i]) begin
            n_fail++;
            $display("FAIL model_table_%0d: got %h want %h", i, ref_prod(xs[i], ys[i]), qs[i]);
         end
         run_op(xs[i], ys[i], "directed");
      end
      for (int i = 0; i < 24; i++) begin
         run_op(3'($urandom), 3'($urandom), "random");
      end
   endtask

   task automatic test_backpressure();
      int lat;
      bus.OutReady = 1'b0;
      bus.X = 3'd3;
      bus.Y = 3'd5;
      bus.InValid = 1'b1;
      @(posedge Clk); #1;
      bus.InValid = 1'b0;
      lat = 0;
      while (bus.OutValid !== 1'b1 && lat < 12) begin
         @(posedge Clk); #1;
         lat++;
      end
      n_cmp++;
      if (lat !== ref_lat(3'd5)) begin n_fail++; $display("FAIL bp_latency: got %0d want %0d", lat, ref_lat(3'd5)); end
      for (int i = 0; i < 6; i++) begin
         bus.InValid = 1'b1;
         bus.X = 3'($urandom);
         bus.Y = 3'($urandom);
         @(posedge Clk); #1;
         n_cmp++;
         if (bus.OutValid !== 1'b1 || bus.Q !== 5'h0F || bus.InReady !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold_%0d: got outvalid=%b q=%h inready=%b want 1 0f 0", i, bus.OutValid, bus.Q, bus.InReady);
         end
      end
      bus.InValid = 1'b0;
      bus.OutReady = 1'b1;
      @(posedge Clk); #1;
      n_cmp++;
      if (bus.InReady !== 1'b1 || bus.OutValid !== 1'b0 || bus.Busy !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_release: got inready=%b outvalid=%b busy=%b want 1 0 0", bus.InReady, bus.OutValid, bus.Busy);
      end
   endtask

   task automatic test_mid_reset();
      bit seen_ov;
      bus.OutReady = 1'b1;
      bus.X = 3'd7;
      bus.Y = 3'd7;
      bus.InValid = 1'b1;
      @(posedge Clk); #1;
      bus.InValid = 1'b0;
      @(posedge Clk); #1;
      Rst = 1'b1;
      #1;
      n_cmp++;
      if (bus.InReady !== 1'b1 || bus.OutValid !== 1'b0 || bus.Busy !== 1'b0 || bus.Q !== 5'h00) begin
         n_fail++;
         $display("FAIL midreset_async: got inready=%b outvalid=%b busy=%b q=%h want 1 0 0 00", bus.InReady, bus.OutValid, bus.Busy, bus.Q);
      end
      @(posedge Clk); #1;
      Rst = 1'b0;
      seen_ov = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge Clk); #1;
         if (bus.OutValid === 1'b1) seen_ov = 1'b1;
      end
      n_cmp++;
      if (seen_ov !== 1'b0) begin n_fail++; $display("FAIL midreset_no_outvalid: got pulse=%b want 0", seen_ov); end
      run_op(3'd2, 3'd3, "after_reset");
   endtask

   task automatic test_zero_skip();
      run_op(3'd5, 3'd1, "y_one");
      run_op(3'd3, 3'd0, "y_zero");
      run_op(3'd6, 3'd2, "y_two");
   endtask

   task automatic test_back_to_back();
      logic [4:0] exp_q [$];
      logic [4:0] want;
      int unsigned outs;
      outs = 0;
      bus.InValid = 1'b1;
      for (int c = 0; c < 200; c++) begin
         bus.X = 3'($urandom);
         bus.Y = 3'($urandom);
         bus.OutReady = (c < 100) ? 1'b1 : 1'($urandom);
         if (bus.InReady === 1'b1) exp_q.push_back(ref_prod(bus.X, bus.Y));
         if (bus.OutValid === 1'b1 && bus.OutReady === 1'b1) begin
            outs++;
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 5'bxxxxx;
            n_cmp++;
            if (bus.Q !== want) begin n_fail++; $display("FAIL b2b_q_%0d: got %h want %h", outs, bus.Q, want); end
         end
         @(posedge Clk); #1;
      end
      bus.InValid = 1'b0;
      bus.OutReady = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (bus.OutValid === 1'b1) begin
            outs++;
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 5'bxxxxx;
            n_cmp++;
            if (bus.Q !== want) begin n_fail++; $display("FAIL b2b_drain_q_%0d: got %h want %h", outs, bus.Q, want); end
         end
         @(posedge Clk); #1;
      end
      n_cmp++;
      if (exp_q.size() != 0 || outs < 20) begin
         n_fail++;
         $display("FAIL b2b_count: got outputs=%0d left=%0d want outputs>=20 left=0", outs, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_products();
      test_backpressure();
      test_mid_reset();
      test_zero_skip();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
